// File: rtl/aqed_fifo_seq.sv
// aqed_fifo_seq: issues one original/filler/duplicate/drain sequence to a FIFO under A-QED check.
module aqed_fifo_seq #(
  parameter int DEPTH   = 64,
  parameter int OCC_W   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [7:0]       gap_len,
  input  logic             full,
  input  logic             empty,
  input  logic             qed_done,
  input  logic             qed_check,
  output logic             wen_out,
  output logic             ren_out,
  output logic             exec_dup,
  output logic             flush_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout_err,
  output logic [OCC_W-1:0] occupancy
);
  localparam int DC_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FLUSH, ORIG, GAP, DUP, DRAIN, FIN} state_t;
  state_t state, next;
  logic [7:0] gap_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic wr_ph;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else if (clk_en) state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? FLUSH : IDLE;
      FLUSH:   next = ORIG;
      ORIG:    next = full ? ORIG : (gap_cnt != 8'd0 ? GAP : DUP);
      GAP:     next = (!full && gap_cnt == 8'd1) ? DUP : GAP;
      DUP:     next = full ? DUP : DRAIN;
      DRAIN:   next = (qed_done || drain_cnt == DC_W'(TIMEOUT)) ? FIN : DRAIN;
      default: next = IDLE;
    endcase
  end
  // Reads while filling only ever relieve a full FIFO, so long gaps cannot deadlock.
  always_comb begin
    wr_ph     = state inside {ORIG, GAP, DUP};
    wen_out   = clk_en && wr_ph && !full;
    ren_out   = clk_en && (wr_ph ? full : (state == DRAIN && !empty));
    exec_dup  = wr_ph || state == DRAIN;
    flush_out = clk_en && state == FLUSH;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gap_cnt     <= '0;
      drain_cnt   <= '0;
      occupancy   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
    end else if (clk_en) begin
      if (state == IDLE && start) begin
        gap_cnt     <= gap_len;
        drain_cnt   <= '0;
        done        <= 1'b0;
        pass        <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state == FLUSH || (state == IDLE && start)) occupancy <= '0;
      else if (wen_out && !ren_out && occupancy != OCC_W'(DEPTH)) occupancy <= occupancy + OCC_W'(1);
      else if (ren_out && !wen_out && occupancy != '0) occupancy <= occupancy - OCC_W'(1);
      if (state == GAP && wen_out) gap_cnt <= gap_cnt - 8'd1;
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DC_W'(1);
        if (next == FIN) begin
          done <= 1'b1;
          if (qed_done) pass <= qed_check;
          else timeout_err <= 1'b1;
        end
      end
    end
endmodule
